fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of the core. Owns the PC and issues word reads to instruction
//  memory over a req/ack handshake. Delivers {pc, instruction, exception} to the IF/ID decode
//  stage through a valid/stall interface, and redirects on taken branches/jumps from EX.
//  Buffering is one output register plus a one-entry skid register, so memory acks are never
//  lost while decode is stalled.
// PARAMETERS
//  RESET_ADDR  32'h0000_0000  PC loaded on reset.
//  NOP_INSN    32'h0000_0013  Instruction delivered with an exception (addi x0,x0,0).
// PORTS
//  clk             in   1   Clock; all state updates on rising edge.
//  rst             in   1   Asynchronous, active-high reset.
//  imem_req        out  1   Read request. Held with stable imem_addr until imem_ack.
//  imem_addr       out  32  Word address of the request; [1:0] always 0.
//  imem_ack        in   1   Response valid. May assert in the same cycle as imem_req.
//  imem_rdata      in   32  Instruction word; sampled when imem_ack=1.
//  imem_err        in   1   Access fault; qualified by imem_ack.
//  branch_taken    in   1   One-cycle redirect pulse from EX.
//  branch_target   in   32  New PC; sampled when branch_taken=1.
//  id_stall        in   1   Decode cannot accept; output is held while asserted.
//  if_valid        out  1   if_pc/if_instruction/if_exc* valid.
//  if_pc           out  32  PC of the delivered instruction.
//  if_instruction  out  32  Fetched word (NOP_INSN when if_exc=1).
//  if_exc          out  1   Fetch exception attached to this entry.
//  if_exc_code     out  4   0 = instruction address misaligned, 1 = instruction access fault.
// BEHAVIOUR
//  Reset (async, immediate)
//   - if_valid=0, if_pc=RESET_ADDR, if_instruction=NOP_INSN, if_exc=0, if_exc_code=0.
//   - imem_req=0; skid empty; kill=0; pc=RESET_ADDR; state=RUN.
//   - Dropping imem_req mid-transaction on reset is permitted.
//  States
//   - RUN: no request outstanding. Assert imem_req (addr=pc) when the skid is empty.
//   - WAIT: request outstanding. Keep imem_req=1 and imem_addr unchanged until imem_ack.
//   - HALT: exception entry delivered; no requests issued until branch_taken.
//   - RUN->WAIT: req issued without ack. WAIT->RUN: on ack.
//   - RUN with req and ack in the same cycle: stay in RUN.
//   - On every non-killed ack: pc <= pc+4.
//  Output handshake
//   - Entry is consumed on an edge where if_valid=1 and id_stall=0.
//   - Output is free when if_valid=0 or the entry is being consumed.
//  Ack routing
//   - Skid empty and output free: response goes to the output register.
//   - Otherwise: response goes to the skid.
//   - Skid moves to output when output is free; skid has priority over a new ack.
//   - A new ack arriving in that same cycle goes to the skid.
//   - No new request is issued while the skid is full. Responses are never dropped except by kill.
//  Throughput
//   - Zero-wait memory, no stall: one instruction per cycle.
//   - First imem_req in the first cycle after rst falls; if_valid=1 at the following edge.
//  Redirect (branch_taken=1; highest priority, beats id_stall)
//   - Next edge: if_valid=0, skid cleared, pc <= branch_target, state -> RUN.
//   - If a request is outstanding without ack this cycle: keep req/addr, set kill, go to WAIT.
//     The killed response is discarded on ack, then fetch resumes at the target.
//   - branch_taken together with imem_ack: that response is discarded and kill is not set.
//  Misaligned redirect (branch_target[1:0] != 0)
//   - Deliver one entry: pc=target, NOP_INSN, if_exc=1, code 0. Enter HALT; no memory access.
//  imem_err on ack
//   - Deliver pc, NOP_INSN, if_exc=1, code 1. Enter HALT once delivered.
//  Width rule
//   - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
// TESTING
//  1. Reset, zero-wait mem returning addr^32'hA5A5_0000, no stall
//     -> if_valid every cycle, if_pc 0,4,8,C with matching words.
//  2. id_stall held 3 cycles with 1-cycle ack latency
//     -> if_pc frozen; skid fills once; no req while skid full.
//     After release: no gap, no duplicate, no lost PC.
//  3. branch_taken, target 32'h100, while a request is outstanding (ack 2 cycles later)
//     -> old response dropped; next delivered if_pc=32'h100; if_valid=0 in between.
//  4. branch_taken, target 32'h102
//     -> one entry: if_pc=32'h102, NOP_INSN, if_exc=1, code 0; imem_req stays 0 until next redirect.
//  5. imem_err=1 on ack for pc 32'h40 -> entry: if_exc=1, code 1, NOP_INSN; HALT.
//  6. rst asserted while in WAIT with skid full
//     -> all outputs at reset values immediately; fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over req/ack and
// hands {pc, instruction, exception} to decode through an output register plus one skid entry.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_exc,
    output logic [3:0]  if_exc_code
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 4;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   insn;
        logic              exc;
        logic [CODE_W-1:0] code;
    } entry_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam entry_t RESET_ENTRY = '{pc: RESET_ADDR, insn: NOP_INSN, exc: 1'b0, code: '0};

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] addr_q, addr_q_n;
    logic            kill, kill_n;
    logic            skid_valid, skid_valid_n;
    entry_t          skid, skid_n;
    logic            out_valid, out_valid_n;
    entry_t          out, out_n;

    logic            req_c;
    logic [XLEN-1:0] req_addr;
    logic            out_free;
    logic            take;
    entry_t          ack_entry;
    entry_t          exc_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_ADDR;
            addr_q     <= RESET_ADDR;
            kill       <= 1'b0;
            skid_valid <= 1'b0;
            skid       <= RESET_ENTRY;
            out_valid  <= 1'b0;
            out        <= RESET_ENTRY;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            addr_q     <= addr_q_n;
            kill       <= kill_n;
            skid_valid <= skid_valid_n;
            skid       <= skid_n;
            out_valid  <= out_valid_n;
            out        <= out_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        addr_q_n     = addr_q;
        kill_n       = kill;
        skid_valid_n = skid_valid;
        skid_n       = skid;
        out_valid_n  = out_valid;
        out_n        = out;

        // Misaligned PCs never reach memory; they surface as an exception entry instead.
        req_c    = ((state == RUN) && !skid_valid && (pc[1:0] == 2'b00)) || (state == WAIT);
        req_addr = (state == WAIT) ? addr_q : {pc[XLEN-1:2], 2'b00};
        out_free = !out_valid || !id_stall;
        take     = req_c && imem_ack && !kill && !branch_taken;

        ack_entry.pc   = req_addr;
        ack_entry.insn = imem_err ? NOP_INSN : imem_rdata;
        ack_entry.exc  = imem_err;
        ack_entry.code = imem_err ? CODE_W'(1) : CODE_W'(0);

        exc_entry.pc   = pc;
        exc_entry.insn = NOP_INSN;
        exc_entry.exc  = 1'b1;
        exc_entry.code = CODE_W'(0);

        if (branch_taken) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
            pc_n         = branch_target;
            kill_n       = 1'b0;
            state_n      = RUN;
            // An unanswered request must stay on the bus; its response is discarded later.
            if (req_c && !imem_ack) begin
                kill_n   = 1'b1;
                state_n  = WAIT;
                addr_q_n = req_addr;
            end
        end else begin
            case (state)
                RUN: begin
                    if (req_c && !imem_ack) begin
                        state_n  = WAIT;
                        addr_q_n = req_addr;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state_n = RUN;
                        kill_n  = 1'b0;
                    end
                end
                default: ;
            endcase

            if (take) begin
                pc_n = pc + XLEN'(4);
                if (imem_err) begin
                    state_n = HALT;
                end
            end

            if (out_valid && !id_stall) begin
                out_valid_n = 1'b0;
            end

            // Skid drains first; a same-cycle response refills it behind.
            if (out_free) begin
                if (skid_valid) begin
                    out_n        = skid;
                    out_valid_n  = 1'b1;
                    skid_valid_n = 1'b0;
                    if (take) begin
                        skid_n       = ack_entry;
                        skid_valid_n = 1'b1;
                    end
                end else if (take) begin
                    out_n       = ack_entry;
                    out_valid_n = 1'b1;
                end else if ((state == RUN) && (pc[1:0] != 2'b00)) begin
                    out_n       = exc_entry;
                    out_valid_n = 1'b1;
                    state_n     = HALT;
                end
            end else if (take) begin
                skid_n       = ack_entry;
                skid_valid_n = 1'b1;
            end
        end
    end

    // Request is suppressed while reset is held so the bus is idle immediately.
    assign imem_req       = req_c && !rst;
    assign imem_addr      = req_addr;
    assign if_valid       = out_valid;
    assign if_pc          = out.pc;
    assign if_instruction = out.insn;
    assign if_exc         = out.exc;
    assign if_exc_code    = out.code;

endmodule
